// File: rtl/program_loader.sv
// program_loader
//
// Boot stage for the 9-bit accumulator computer. It accepts a program as a
// byte stream over a valid/ready handshake and writes it into a 16x9
// instruction memory. The CPU is held halted until a complete, well-formed
// program has been written. A start pulse at any time restarts loading.
//
// Stream format: length byte N (1..DEPTH), then N pairs (low, high).
// Each instruction is {high[0], low[7:0]}. high[7:1] must be zero.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse, begins a new load session
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle (registered)
//   we           instruction memory write enable, one-cycle pulse
//   waddr        instruction memory write address
//   wdata        instruction memory write data
//   run          CPU enable
//   error        malformed stream seen, sticky until next start
//   loaded_count instructions written in the current or last session
module program_loader #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [INSTR_W-1:0] wdata,
    output logic               run,
    output logic               error,
    output logic [ADDR_W:0]    loaded_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LO,
        S_HI,
        S_FLUSH,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    state_t              state_reg, state_next;
    logic                in_ready_reg;
    logic                we_reg;
    logic                run_reg;
    logic                error_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic [INSTR_W-1:0]  wdata_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     len_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [7:0]          low_reg;

    logic xfer;
    logic len_bad;
    logic high_bad;
    logic last_pair;

    assign xfer      = in_valid && in_ready_reg;
    assign len_bad   = (in_data == 8'd0) || (in_data > DEPTH_B);
    assign high_bad  = |in_data[7:1];
    // addr never passes N-1, so the last pair is recognised by equality.
    assign last_pair = ({1'b0, addr_reg} == (len_reg - ONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start overrides everything, including a byte
    // transfer on the same edge.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = S_LEN;
        end else begin
            case (state_reg)
                S_LEN:   if (xfer) state_next = len_bad ? S_ERROR : S_LO;
                S_LO:    if (xfer) state_next = S_HI;
                S_HI:    if (xfer) state_next = high_bad  ? S_ERROR :
                                                last_pair ? S_FLUSH : S_LO;
                S_FLUSH: state_next = S_RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    // Datapath and registered outputs. Status outputs are derived from
    // state_next so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            run_reg      <= 1'b0;
            error_reg    <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            count_reg    <= '0;
            len_reg      <= '0;
            addr_reg     <= '0;
            low_reg      <= '0;
        end else begin
            in_ready_reg <= (state_next == S_LEN) || (state_next == S_LO) ||
                            (state_next == S_HI);
            run_reg      <= (state_next == S_RUN);
            error_reg    <= (state_next == S_ERROR);
            we_reg       <= 1'b0;

            if (start) begin
                count_reg <= '0;
            end else begin
                case (state_reg)
                    S_LEN: begin
                        if (xfer && !len_bad) begin
                            len_reg   <= in_data[ADDR_W:0];
                            addr_reg  <= '0;
                            count_reg <= '0;
                        end
                    end
                    S_LO: begin
                        if (xfer) begin
                            low_reg <= in_data;
                        end
                    end
                    S_HI: begin
                        if (xfer && !high_bad) begin
                            we_reg    <= 1'b1;
                            waddr_reg <= addr_reg;
                            wdata_reg <= INSTR_W'({in_data[0], low_reg});
                            count_reg <= count_reg + ONE;
                            if (!last_pair) begin
                                addr_reg <= addr_reg + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign we           = we_reg;
    assign waddr        = waddr_reg;
    assign wdata        = wdata_reg;
    assign run          = run_reg;
    assign error        = error_reg;
    assign loaded_count = count_reg;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the 9-bit accumulator computer.
- Receives a program as a byte stream over a valid/ready handshake and writes it into a writable 16x9 instruction memory. The memory has an address/data/write-enable port.
- Holds the CPU halted (run low) until a complete, well-formed program is written.
- A start pulse at any time restarts loading, so the program can be reloaded without reset.

Parameters:
- ADDR_W, 4, instruction memory address width.
- INSTR_W, 9, instruction width. Fixed at 9 for this encoding: bit 8 comes from the high byte.
- DEPTH, 16, number of instruction slots. Must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new load session.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- we  output  1  instruction memory write enable, one-cycle pulse.
- waddr  output  ADDR_W  instruction memory write address.
- wdata  output  INSTR_W  instruction memory write data.
- run  output  1  CPU enable; gates PC advance.
- error  output  1  malformed stream detected; sticky until next start.
- loaded_count  output  ADDR_W+1  instructions written in the current or last session.

Behaviour:
- Clocking and reset:
  - One clock domain. rst_n is asynchronous assert, synchronous release.
  - Reset values: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, run=0, error=0, loaded_count=0.
- Handshake:
  - A byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is a registered function of state: 1 only in LEN, LO, HI.
  - in_data is ignored when no transfer occurs.
- Stream format: length byte N, then N pairs of (low byte, high byte).
  - Each instruction = {high[0], low[7:0]}.
  - high[7:1] must be zero.
- IDLE: in_ready=0, run=0. start -> LEN.
- LEN:
  - On transfer, N=0 or N>DEPTH -> ERROR.
  - Otherwise store N, clear addr and loaded_count -> LO.
- LO: on transfer, latch low byte -> HI.
- HI: on transfer:
  - If high[7:1]!=0 -> ERROR; no write is issued for this pair.
  - Otherwise, in the next cycle: we=1, waddr=addr, wdata={high[0],low}, loaded_count+=1.
  - If addr==N-1 -> FLUSH. Otherwise addr+=1 -> LO.
- Write timing:
  - we is high exactly one cycle per instruction.
  - waddr and wdata are stable while we=1 and hold their last value afterwards.
- FLUSH: one cycle, in_ready=0. Guarantees the last write has landed -> RUN.
- RUN: run=1, in_ready=0.
  - Timing: last HI transfer at edge T; we=1 during cycle T+1; run=1 from cycle T+2.
- ERROR: error=1, run=0, in_ready=0. Addresses already written are not rolled back.
- start priority:
  - start in any state (LEN/LO/HI/FLUSH/RUN/ERROR) -> LEN next edge.
  - The same edge clears run, error and loaded_count, and drops any pending partial pair.
  - start wins over a simultaneous byte transfer; that byte is discarded and in_ready reads 1 only in the following LEN cycle.
  - A write already scheduled from the previous edge still completes.
- Wrap-around: addr never exceeds N-1, so no address wrap. N=DEPTH writes 0..15 exactly once.
- Reset mid-session: immediately returns to reset values. The partially written memory is not cleared.

Test Plan:
- Reset, start, stream 02,05,00,3A,01 with in_valid held high -> we pulses at addr 0 data 0x005 and addr 1 data 0x13A. run=1 two cycles after the last transfer. loaded_count=2, error=0.
- Same stream with in_valid toggling every other cycle and random gaps -> identical writes and final state. No byte is accepted when in_ready=0.
- Length byte 0x11 (17) -> ERROR, no we pulse. A following start plus length 0x10 and 16 pairs -> addrs 0..15 written once each, run=1, loaded_count=16.
- Pair (0xFF, 0x02) at the second instruction -> first write done, no second write, error=1, run=0, loaded_count=1.
- start asserted while in HI mid-stream -> next state LEN, pending low byte dropped, no write for it. A new full load then completes normally.
- rst_n asserted low while in RUN or during HI -> all outputs at reset values asynchronously, without waiting for a clock edge. After release the block stays in IDLE with in_ready=0 until start.
